fifo_id_pipe: RTL and testbench
===============================

Name: fifo_id_pipe

Overview:
- Parametrised multi-lane pipeline register between the fetch buffer (FIFO stage) and the decoder (ID stage). It replaces the fixed dual-instruction FIFO/ID latch.
- Carries up to LANES instructions per cycle, with per-lane valid mask and PC, over a full valid/ready handshake.
- A 2-entry skid buffer keeps in_ready registered, so no combinational ready path runs from the decoder back to the fetch buffer.
- Supports stall, flush with cause capture, and a saturating bubble-cycle performance counter.

Parameters:
- LANES, 2, instructions per bundle (1..4).
- INST_W, 32, instruction width.
- PC_W, 32, PC width.
- NOP_INST, 32'h03400000, encoding driven on invalid or flushed lanes.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous flush of all held bundles.
- flush_cause  in  2  cause tag, captured on flush.
- stall  in  1  hold output; suppress out_valid.
- in_valid  in  1  fetch buffer offers a bundle.
- in_ready  out  1  this block can accept a bundle.
- in_mask  in  LANES  per-lane valid; lane 0 is oldest.
- in_inst  in  LANES*INST_W  instructions; lane i at bits [i*INST_W +: INST_W].
- in_pc  in  LANES*PC_W  PCs, packed the same way.
- out_valid  out  1  bundle presented to the decoder.
- out_ready  in  1  decoder accepts.
- out_mask  out  LANES  per-lane valid of the presented bundle.
- out_inst  out  LANES*INST_W  presented instructions.
- out_pc  out  LANES*PC_W  presented PCs.
- last_flush_cause  out  2  cause of the most recent flush.
- bubble_cnt  out  CNT_W  saturating count of cycles with no bundle held and no stall.

Behaviour:
- Reset (rstn=0, asynchronous):
  - main and skid entries invalid.
  - out_valid=0, out_mask=0, every out_inst lane=NOP_INST, out_pc=0.
  - last_flush_cause=0, bubble_cnt=0.
  - in_ready=1, because it is a pure function of the skid-empty register.
- Storage: main entry M (drives the outputs) and skid entry S. in_ready = !S.valid, with no dependency on out_ready or stall.
- Transfer definitions:
  - acc = in_valid & in_ready.
  - take = out_valid & out_ready.
  - out_valid = M.valid & !stall.
- Bubble bundle: a bundle with in_mask==0 is accepted (acc) but never stored.
- Per-cycle update, normal case (no flush):
  - M empty, acc: bundle into M. It is visible on the outputs the next cycle (1-cycle latency).
  - M full, take, S empty, acc: new bundle into M.
  - M full, take, S full: S moves to M and S is cleared. No acc is possible because in_ready=0.
  - M full, no take, acc: bundle into S, so in_ready=0 next cycle.
  - M full, take, no acc, S empty: M is cleared.
- Ordering: bundles leave in acceptance order, with no duplication and no loss.
- Stall:
  - out_valid=0, so no take occurs.
  - out_mask, out_inst and out_pc are held stable.
  - Acceptance continues into S while S is empty.
- Flush:
  - Has priority over acc, take and stall in the same cycle. The incoming bundle is dropped even if acc=1.
  - Next cycle: M and S invalid, out_mask=0, out_inst=NOP_INST on all lanes, in_ready=1.
  - last_flush_cause <= flush_cause.
- Output lanes:
  - Any lane whose out_mask bit is 0 drives NOP_INST; its PC is don't-care, driven 0.
  - When M is invalid, all lanes are NOP_INST and out_mask=0.
- bubble_cnt:
  - Increments on each cycle where !M.valid & !stall & !flush.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - Cleared only by reset.
- Reset mid-operation: the asynchronous clear wins immediately and all held bundles are lost.
- Outputs are registered or decoded from registers only. The sole combinational input-to-output path is stall -> out_valid.

Test Plan:
- Reset, then in_valid=1, mask=2'b11, inst={32'h0280_0421, 32'h0280_0842}, pc={0x1c000004, 0x1c000000} -> next cycle out_valid=1 with identical inst/pc and out_mask=2'b11; bubble_cnt=1 (only the post-reset empty cycle counted).
- out_ready=0 with three back-to-back bundles A, B, C -> A in M, B in S, in_ready=0 after B, C held by the source. Raise out_ready -> A, B, C delivered in order, one per cycle.
- mask=2'b01 -> out_inst lane 1 = 32'h03400000 and out_mask=2'b01. A bundle with mask=0 -> accepted, never presented, and out_valid stays 0.
- M and S both full, flush=1 with cause=2'b10 and in_valid=1 in the same cycle -> next cycle out_valid=0, out_mask=0, in_ready=1, last_flush_cause=2'b10, and the incoming bundle is absent from all later outputs.
- stall=1 for 3 cycles while M is valid and out_ready=1 -> out_valid=0, outputs unchanged, one extra bundle accepted into S. Drop stall -> both bundles drain in order.
- CNT_W=4, idle for 20 cycles -> bubble_cnt saturates at 15. Assert rstn=0 mid-transfer -> all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fifo_id_pipe.sv
// Pipeline register between the fetch buffer and the decoder: a main entry plus a
// 2nd skid entry so in_ready depends only on a register, with flush and bubble counting.
module fifo_id_pipe #(
  parameter int                 LANES    = 2,
  parameter int                 INST_W   = 32,
  parameter int                 PC_W     = 32,
  parameter logic [INST_W-1:0]  NOP_INST = 32'h03400000,
  parameter int                 CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    flush,
  input  logic [1:0]              flush_cause,
  input  logic                    stall,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES-1:0]        in_mask,
  input  logic [LANES*INST_W-1:0] in_inst,
  input  logic [LANES*PC_W-1:0]   in_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES-1:0]        out_mask,
  output logic [LANES*INST_W-1:0] out_inst,
  output logic [LANES*PC_W-1:0]   out_pc,
  output logic [1:0]              last_flush_cause,
  output logic [CNT_W-1:0]        bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                    m_valid_q, m_valid_d;
  logic [LANES-1:0]        m_mask_q, m_mask_d;
  logic [LANES*INST_W-1:0] m_inst_q, m_inst_d;
  logic [LANES*PC_W-1:0]   m_pc_q, m_pc_d;
  logic                    s_valid_q, s_valid_d;
  logic [LANES-1:0]        s_mask_q, s_mask_d;
  logic [LANES*INST_W-1:0] s_inst_q, s_inst_d;
  logic [LANES*PC_W-1:0]   s_pc_q, s_pc_d;
  logic [1:0]              cause_q, cause_d;
  logic [CNT_W-1:0]        bubble_q, bubble_d;

  logic acc, take, store;

  assign in_ready         = ~s_valid_q;
  assign out_valid        = m_valid_q & ~stall;
  assign acc              = in_valid & in_ready;
  assign take             = out_valid & out_ready;
  // An all-invalid bundle is consumed from the source but never occupies an entry.
  assign store            = acc & (|in_mask);
  assign last_flush_cause = cause_q;
  assign bubble_cnt       = bubble_q;

  always_comb begin
    m_valid_d = m_valid_q;
    m_mask_d  = m_mask_q;
    m_inst_d  = m_inst_q;
    m_pc_d    = m_pc_q;
    s_valid_d = s_valid_q;
    s_mask_d  = s_mask_q;
    s_inst_d  = s_inst_q;
    s_pc_d    = s_pc_q;
    cause_d   = cause_q;
    bubble_d  = bubble_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
      cause_d   = flush_cause;
    end else if (!m_valid_q || take) begin
      if (m_valid_q && s_valid_q) begin
        m_mask_d  = s_mask_q;
        m_inst_d  = s_inst_q;
        m_pc_d    = s_pc_q;
        s_valid_d = 1'b0;
      end else if (store) begin
        m_valid_d = 1'b1;
        m_mask_d  = in_mask;
        m_inst_d  = in_inst;
        m_pc_d    = in_pc;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (store) begin
      s_valid_d = 1'b1;
      s_mask_d  = in_mask;
      s_inst_d  = in_inst;
      s_pc_d    = in_pc;
    end
    if (!m_valid_q && !stall && !flush && (bubble_q != CNT_MAX)) begin
      bubble_d = bubble_q + CNT_W'(1);
    end
  end

  always_comb begin
    out_mask = '0;
    out_inst = '0;
    out_pc   = '0;
    for (int i = 0; i < LANES; i++) begin
      if (m_valid_q && m_mask_q[i]) begin
        out_mask[i]                 = 1'b1;
        out_inst[i*INST_W +: INST_W] = m_inst_q[i*INST_W +: INST_W];
        out_pc[i*PC_W +: PC_W]       = m_pc_q[i*PC_W +: PC_W];
      end else begin
        out_inst[i*INST_W +: INST_W] = NOP_INST;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid_q <= 1'b0;
      m_mask_q  <= '0;
      m_inst_q  <= '0;
      m_pc_q    <= '0;
      s_valid_q <= 1'b0;
      s_mask_q  <= '0;
      s_inst_q  <= '0;
      s_pc_q    <= '0;
      cause_q   <= '0;
      bubble_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_mask_q  <= m_mask_d;
      m_inst_q  <= m_inst_d;
      m_pc_q    <= m_pc_d;
      s_valid_q <= s_valid_d;
      s_mask_q  <= s_mask_d;
      s_inst_q  <= s_inst_d;
      s_pc_q    <= s_pc_d;
      cause_q   <= cause_d;
      bubble_q  <= bubble_d;
    end
  end

endmodule

// File: tb/tb_fifo_id_pipe.sv
// Scoreboard bench for fifo_id_pipe: a queue of accepted bundles models the held
// contents; a separate monitor compares and pops whenever the decoder takes a bundle.
module tb_fifo_id_pipe;

  localparam int          LANES  = 2;
  localparam int          INST_W = 32;
  localparam int          PC_W   = 32;
  localparam int          CNT_W  = 4;
  localparam logic [31:0] NOP    = 32'h03400000;

  typedef struct packed {
    logic [LANES-1:0]        mask;
    logic [LANES*INST_W-1:0] inst;
    logic [LANES*PC_W-1:0]   pc;
  } bundle_t;

  logic                    clk = 1'b0;
  logic                    rstn = 1'b0;
  logic                    flush = 1'b0;
  logic [1:0]              flush_cause = '0;
  logic                    stall = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [LANES-1:0]        in_mask = '0;
  logic [LANES*INST_W-1:0] in_inst = '0;
  logic [LANES*PC_W-1:0]   in_pc = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic [LANES-1:0]        out_mask;
  logic [LANES*INST_W-1:0] out_inst;
  logic [LANES*PC_W-1:0]   out_pc;
  logic [1:0]              last_flush_cause;
  logic [CNT_W-1:0]        bubble_cnt;

  int      total = 0;
  int      bad = 0;
  bundle_t sb[$];
  int      preSize = 0;
  int      expBubble = 0;
  logic [1:0] expCause = '0;
  logic    lastAcc = 1'b0;

  fifo_id_pipe #(
    .LANES(LANES), .INST_W(INST_W), .PC_W(PC_W), .NOP_INST(NOP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .flush_cause(flush_cause), .stall(stall),
    .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask), .in_inst(in_inst),
    .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready), .out_mask(out_mask),
    .out_inst(out_inst), .out_pc(out_pc), .last_flush_cause(last_flush_cause),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // What the decoder should see for a held bundle: masked-off lanes become NOP with PC 0.
  function automatic logic [LANES*INST_W-1:0] viewInst(input bundle_t b);
    logic [LANES*INST_W-1:0] r;
    for (int l = 0; l < LANES; l++)
      r[l*INST_W +: INST_W] = b.mask[l] ? b.inst[l*INST_W +: INST_W] : NOP;
    return r;
  endfunction

  function automatic logic [LANES*PC_W-1:0] viewPc(input bundle_t b);
    logic [LANES*PC_W-1:0] r;
    for (int l = 0; l < LANES; l++)
      r[l*PC_W +: PC_W] = b.mask[l] ? b.pc[l*PC_W +: PC_W] : '0;
    return r;
  endfunction

  // Monitor: checks the presented state against the queue head, pops on each take.
  initial begin
    bundle_t head;
    forever begin
      @(negedge clk);
      #1;
      preSize = sb.size();
      if (rstn) begin
        checkOutput("in_ready", {127'b0, in_ready}, {127'b0, preSize < 2});
        checkOutput("out_valid", {127'b0, out_valid}, {127'b0, (preSize > 0) && !stall});
        checkOutput("bubble_cnt", 128'(bubble_cnt), 128'(expBubble));
        checkOutput("last_flush_cause", 128'(last_flush_cause), 128'(expCause));
        if (preSize > 0) begin
          head = sb[0];
          checkOutput("out_mask", 128'(out_mask), 128'(head.mask));
          checkOutput("out_inst", 128'(out_inst), 128'(viewInst(head)));
          checkOutput("out_pc", 128'(out_pc), 128'(viewPc(head)));
        end else begin
          checkOutput("empty_mask", 128'(out_mask), 128'(0));
          checkOutput("empty_inst", 128'(out_inst), {64'b0, NOP, NOP});
          checkOutput("empty_pc", 128'(out_pc), 128'(0));
        end
        if (out_valid && out_ready && !flush) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL take_on_empty: got out_valid=1 expected no bundle held");
          end else begin
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  task automatic updateModel(input logic v, input bundle_t b, input logic st, input logic fl,
                             input logic [1:0] c);
    lastAcc = v && (preSize < 2);
    if (fl) begin
      sb.delete();
      expCause = c;
    end else if (lastAcc && (b.mask != '0)) begin
      sb.push_back(b);
    end
    if ((preSize == 0) && !st && !fl && (expBubble < 15)) expBubble++;
  endtask

  task automatic applyStimulus(input logic v, input logic [LANES-1:0] m,
                               input logic [LANES*INST_W-1:0] i, input logic [LANES*PC_W-1:0] p,
                               input logic rdy, input logic st, input logic fl,
                               input logic [1:0] c);
    bundle_t b;
    @(negedge clk);
    in_valid    = v;
    in_mask     = m;
    in_inst     = i;
    in_pc       = p;
    out_ready   = rdy;
    stall       = st;
    flush       = fl;
    flush_cause = c;
    #2;
    b.mask = m;
    b.inst = i;
    b.pc   = p;
    updateModel(v, b, st, fl, c);
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(1'b0, '0, '0, '0, rdy, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic releaseReset();
    bundle_t b;
    @(negedge clk);
    in_valid = 1'b0; in_mask = '0; in_inst = '0; in_pc = '0;
    out_ready = 1'b0; stall = 1'b0; flush = 1'b0; flush_cause = '0;
    rstn = 1'b1;
    #2;
    b = '0;
    updateModel(1'b0, b, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_out_valid"}, {127'b0, out_valid}, 128'(0));
    checkOutput({tag, "_in_ready"}, {127'b0, in_ready}, 128'(1));
    checkOutput({tag, "_out_mask"}, 128'(out_mask), 128'(0));
    checkOutput({tag, "_out_inst"}, 128'(out_inst), {64'b0, NOP, NOP});
    checkOutput({tag, "_out_pc"}, 128'(out_pc), 128'(0));
    checkOutput({tag, "_cause"}, 128'(last_flush_cause), 128'(0));
    checkOutput({tag, "_bubble"}, 128'(bubble_cnt), 128'(0));
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    logic [63:0] instA, instB, instC;
    repeat (3) @(negedge clk);
    #1;
    checkResetValues("reset");
    releaseReset();

    // First bundle straight through, then taken
    applyStimulus(1'b1, 2'b11, {32'h0280_0421, 32'h0280_0842}, {32'h1c00_0004, 32'h1c00_0000},
                  1'b1, 1'b0, 1'b0, 2'b00);
    idle(1'b1);
    idle(1'b1);

    // Back-pressure: A, B, C offered with the decoder blocked; C is held by the source
    instA = rnd64(); instB = rnd64(); instC = rnd64();
    applyStimulus(1'b1, 2'b11, instA, 64'h10, 1'b0, 1'b0, 1'b0, 2'b00);
    applyStimulus(1'b1, 2'b11, instB, 64'h20, 1'b0, 1'b0, 1'b0, 2'b00);
    applyStimulus(1'b1, 2'b11, instC, 64'h30, 1'b0, 1'b0, 1'b0, 2'b00);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 2'b11, instC, 64'h30, 1'b1, 1'b0, 1'b0, 2'b00);
      if (lastAcc) break;
    end
    repeat (4) idle(1'b1);

    // Partial mask and an all-invalid bundle
    applyStimulus(1'b1, 2'b01, rnd64(), 64'h0000_0044_0000_0040, 1'b1, 1'b0, 1'b0, 2'b00);
    applyStimulus(1'b1, 2'b00, rnd64(), 64'h50, 1'b1, 1'b0, 1'b0, 2'b00);
    repeat (2) idle(1'b1);

    // Flush with both entries full and a bundle offered in the same cycle
    applyStimulus(1'b1, 2'b11, rnd64(), 64'h60, 1'b0, 1'b0, 1'b0, 2'b00);
    applyStimulus(1'b1, 2'b10, rnd64(), 64'h70, 1'b0, 1'b0, 1'b0, 2'b00);
    applyStimulus(1'b1, 2'b11, rnd64(), 64'h80, 1'b0, 1'b0, 1'b1, 2'b10);
    repeat (3) idle(1'b1);

    // Stall with the decoder ready: one more bundle slips into the skid entry
    applyStimulus(1'b1, 2'b11, rnd64(), 64'h90, 1'b1, 1'b0, 1'b0, 2'b00);
    applyStimulus(1'b1, 2'b11, rnd64(), 64'hA0, 1'b1, 1'b1, 1'b0, 2'b00);
    applyStimulus(1'b0, 2'b00, '0, '0, 1'b1, 1'b1, 1'b0, 2'b00);
    applyStimulus(1'b0, 2'b00, '0, '0, 1'b1, 1'b1, 1'b0, 2'b00);
    repeat (3) idle(1'b1);

    // Long idle run drives the bubble counter into saturation
    repeat (20) idle(1'b0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), rnd64(), rnd64(),
                    $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 15) == 0, 2'($urandom_range(0, 3)));
    end

    // Asynchronous reset in the middle of traffic, between clock edges
    applyStimulus(1'b1, 2'b11, rnd64(), 64'hB0, 1'b0, 1'b0, 1'b0, 2'b00);
    applyStimulus(1'b1, 2'b11, rnd64(), 64'hC0, 1'b0, 1'b0, 1'b0, 2'b00);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    checkResetValues("midreset");
    sb.delete();
    expBubble = 0;
    expCause  = '0;
    releaseReset();
    for (int n = 0; n < 40; n++) begin
      applyStimulus($urandom_range(0, 1) != 0, 2'($urandom_range(0, 3)), rnd64(), rnd64(),
                    $urandom_range(0, 1) != 0, 1'b0, 1'b0, 2'b00);
    end
    repeat (4) idle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
